// File: rtl/fan_adder_pipe.sv
// Two-stage handshaked reduction node: operand select (S1), then zero/add/bypass/accumulate into the output register.
// Optional FAN_ADDER_SAT_EN: add and accumulate results saturate to the signed DW_OUT range instead of wrapping.
module fan_adder_pipe #(
  parameter int DW_DATA = 8,
  parameter int NUM_IN  = 4,
  parameter int SEL_IN  = 2,
  parameter int DW_OUT  = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [DW_DATA*NUM_IN-1:0]   in_data,
  input  logic [2*SEL_IN-1:0]         sel,
  input  logic [1:0]                  mode,
  input  logic                        last,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [2*DW_OUT-1:0]         out_data,
  output logic                        out_last
);

  typedef enum logic [1:0] {
    MODE_ZERO   = 2'b00,
    MODE_ADD    = 2'b01,
    MODE_BYPASS = 2'b10,
    MODE_ACC    = 2'b11
  } mode_t;

  // Saturating build needs headroom for acc+A+B before clamping; wrap build works in DW_OUT directly.
`ifdef FAN_ADDER_SAT_EN
  localparam int DW_W = DW_OUT + 2;
`else
  localparam int DW_W = DW_OUT;
`endif

  function automatic logic [DW_OUT-1:0] pick_lane(input logic [DW_DATA*NUM_IN-1:0] lanes,
                                                  input logic [SEL_IN-1:0]         idx);
    logic [DW_OUT-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < NUM_IN; i++) begin
      if (32'(idx) == i)
        r = {{(DW_OUT-DW_DATA){lanes[i*DW_DATA+DW_DATA-1]}}, lanes[i*DW_DATA +: DW_DATA]};
    end
    return r;
  endfunction

  function automatic logic signed [DW_W-1:0] widen(input logic [DW_OUT-1:0] v);
    return DW_W'($signed(v));
  endfunction

  function automatic logic [DW_OUT-1:0] fit(input logic signed [DW_W-1:0] v);
`ifdef FAN_ADDER_SAT_EN
    logic signed [DW_W-1:0] hi;
    logic signed [DW_W-1:0] lo;
    hi = widen({1'b0, {(DW_OUT-1){1'b1}}});
    lo = widen({1'b1, {(DW_OUT-1){1'b0}}});
    if (v > hi)      return hi[DW_OUT-1:0];
    else if (v < lo) return lo[DW_OUT-1:0];
    else             return v[DW_OUT-1:0];
`else
    return v;
`endif
  endfunction

  logic                   s1_valid;
  logic                   s1_last;
  mode_t                  s1_mode;
  logic [DW_OUT-1:0]      s1_a;
  logic [DW_OUT-1:0]      s1_b;
  logic [DW_OUT-1:0]      acc;
  logic                   adv;
  logic signed [DW_W-1:0] add_wide;
  logic signed [DW_W-1:0] acc_wide;
  logic [DW_OUT-1:0]      add_res;
  logic [DW_OUT-1:0]      acc_res;

  assign adv      = s1_valid && (!out_valid || out_ready);
  assign in_ready = !s1_valid || adv;

  always_comb begin
    add_wide = widen(s1_a) + widen(s1_b);
    acc_wide = widen(acc) + add_wide;
    add_res  = fit(add_wide);
    acc_res  = fit(acc_wide);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_mode  <= MODE_ZERO;
      s1_a     <= '0;
      s1_b     <= '0;
    end else if (in_valid && in_ready) begin
      s1_valid <= 1'b1;
      s1_last  <= last;
      s1_mode  <= mode_t'(mode);
      s1_a     <= pick_lane(in_data, sel[SEL_IN-1:0]);
      s1_b     <= pick_lane(in_data, sel[2*SEL_IN-1:SEL_IN]);
    end else if (adv) begin
      s1_valid <= 1'b0;
    end
  end

  // A non-closing accumulate beat still frees the output slot, so out_valid follows the normal drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      acc       <= '0;
    end else if (adv) begin
      unique case (s1_mode)
        MODE_ZERO: begin
          out_valid <= 1'b1;
          out_data  <= '0;
          out_last  <= 1'b0;
        end
        MODE_ADD: begin
          out_valid <= 1'b1;
          out_data  <= {add_res, add_res};
          out_last  <= 1'b0;
        end
        MODE_BYPASS: begin
          out_valid <= 1'b1;
          out_data  <= {s1_b, s1_a};
          out_last  <= 1'b0;
        end
        MODE_ACC: begin
          if (s1_last) begin
            out_valid <= 1'b1;
            out_data  <= {acc_res, acc_res};
            out_last  <= 1'b1;
            acc       <= '0;
          end else begin
            out_valid <= 1'b0;
            acc       <= acc_res;
          end
        end
      endcase
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
